// File: rtl/mux_scan_if.sv
// rtl/mux_scan_if.sv - Handshake and mux bus between a scan controller and its consumer/mux
//
// Signals:
//   start   scan request
//   stop    ends a continuous scan (only meaningful with SCAN_CONTINUOUS_EN)
//   mask    32-bit channel enable mask
//   mux_out byte returned by the downstream 32:1 mux for the current sel
//   ready   consumer accepts data when valid and ready are both high
//   sel     mux select
//   data    captured byte
//   ch      channel index of data
//   valid   data/ch valid
//   busy    controller is not idle
//   done    one-cycle end-of-scan pulse
// Modports: master = requester/consumer/mux side, slave = scan controller.

interface mux_scan_if;
    logic        start;
    logic        stop;
    logic [31:0] mask;
    logic [7:0]  mux_out;
    logic        ready;
    logic [4:0]  sel;
    logic [7:0]  data;
    logic [4:0]  ch;
    logic        valid;
    logic        busy;
    logic        done;

    modport master (
        output start, stop, mask, mux_out, ready,
        input  sel, data, ch, valid, busy, done
    );

    modport slave (
        input  start, stop, mask, mux_out, ready,
        output sel, data, ch, valid, busy, done
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - Scans enabled channels of a 32:1 byte mux and hands bytes to a consumer
//
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  mux_scan_if.slave (start/stop/mask/mux_out/ready in; sel/data/ch/valid/busy/done out)
// Parameter:
//   SETTLE_CYC (1-15) cycles sel is held before mux_out is captured
// Configuration macro:
//   SCAN_CONTINUOUS_EN  when defined, the scan wraps to the lowest enabled channel
//                       (pulsing done at each wrap) until stop is seen.

module mux_scan_ctrl #(
    parameter int SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    mux_scan_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] mask_q;
    logic [3:0]  cnt;
    logic [4:0]  nxt_sel;
    logic        nxt_found;

    function automatic logic [4:0] lowest_bit(input logic [31:0] m);
        logic [4:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) r = 5'(i);
        end
        return r;
    endfunction

    // Next enabled channel strictly above the current sel; channel 31 is the last candidate.
    always_comb begin
        nxt_found = 1'b0;
        nxt_sel   = '0;
        for (int i = 31; i >= 0; i--) begin
            if (mask_q[i] && (5'(i) > bus.sel)) begin
                nxt_found = 1'b1;
                nxt_sel   = 5'(i);
            end
        end
    end

`ifndef SCAN_CONTINUOUS_EN
    logic unused_stop;
    assign unused_stop = bus.stop;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start && (bus.mask != '0)) state_next = SETTLE;
            end
            SETTLE: begin
`ifdef SCAN_CONTINUOUS_EN
                if (bus.stop)          state_next = IDLE;
                else if (cnt == '0)    state_next = HOLD;
`else
                if (cnt == '0)         state_next = HOLD;
`endif
            end
            HOLD: begin
                if (bus.ready) begin
`ifdef SCAN_CONTINUOUS_EN
                    state_next = bus.stop ? IDLE : SETTLE;
`else
                    state_next = nxt_found ? SETTLE : IDLE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy = (state != IDLE);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q    <= '0;
            cnt       <= '0;
            bus.sel   <= '0;
            bus.data  <= '0;
            bus.ch    <= '0;
            bus.valid <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.mask != '0) begin
                            mask_q  <= bus.mask;
                            bus.sel <= lowest_bit(bus.mask);
                            cnt     <= 4'(SETTLE_CYC);
                        end else begin
                            bus.done <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
`ifdef SCAN_CONTINUOUS_EN
                    if (!bus.stop) begin
`else
                    begin
`endif
                        // Capture one cycle after the counter hits zero: SETTLE_CYC+1 latency.
                        if (cnt == '0) begin
                            bus.data  <= bus.mux_out;
                            bus.ch    <= bus.sel;
                            bus.valid <= 1'b1;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.ready) begin
                        bus.valid <= 1'b0;
`ifdef SCAN_CONTINUOUS_EN
                        if (!bus.stop) begin
                            cnt <= 4'(SETTLE_CYC);
                            if (nxt_found) begin
                                bus.sel <= nxt_sel;
                            end else begin
                                bus.done <= 1'b1;
                                bus.sel  <= lowest_bit(mask_q);
                            end
                        end
`else
                        if (nxt_found) begin
                            bus.sel <= nxt_sel;
                            cnt     <= 4'(SETTLE_CYC);
                        end else begin
                            bus.done <= 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 1, range 1-15: cycles sel is held before mux_out is captured.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  scan request; honoured only in IDLE.
REQ-005 stop  input  1  ends a continuous scan; only used when SCAN_CONTINUOUS_EN is defined.
REQ-006 mask  input  32  channel enable mask; bit n enables channel n; sampled on the accepted start.
REQ-007 mux_out  input  8  byte returned by the downstream 32:1 byte mux for the current sel.
REQ-008 sel  output  5  drives the mux select.
REQ-009 data  output  8  captured byte.
REQ-010 ch  output  5  channel index of data.
REQ-011 valid  output  1  data/ch are valid.
REQ-012 ready  input  1  consumer accepts data when valid and ready are both high.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse at the end of a scan.

Function
REQ-015 The block SHALL implement states IDLE, SETTLE, HOLD.
REQ-016 In IDLE, start=1 with mask!=0 SHALL latch mask, set sel to its lowest set bit, load the settle counter with SETTLE_CYC, and enter SETTLE.
REQ-017 In IDLE, start=1 with mask==0 SHALL pulse done on the next cycle, stay in IDLE, and leave valid low.
REQ-018 In SETTLE, the counter SHALL decrement each cycle; in the cycle it reaches 0, data<=mux_out, ch<=sel, valid<=1, and the state SHALL become HOLD.
REQ-019 Latency SHALL be SETTLE_CYC+1 cycles from the sel update to valid rising.
REQ-020 In HOLD with valid=1 and ready=0, data, ch, valid and sel SHALL stay stable.
REQ-021 In HOLD with ready=1, valid SHALL clear, and sel SHALL advance to the next set bit of the latched mask strictly above the current sel, with the state returning to SETTLE.
REQ-022 In HOLD with ready=1 and no higher set bit, done SHALL pulse, valid SHALL clear, and the state SHALL return to IDLE; sel SHALL hold its last value.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 Changes to mask after it is latched SHALL have no effect until the next accepted start.
REQ-025 Channel 31 SHALL be the last candidate; the 5-bit search SHALL never wrap except as permitted by REQ-030.
REQ-026 valid SHALL never be high outside HOLD, and done and valid SHALL never both be high in the same cycle.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL enter IDLE with sel=0, data=0, ch=0, valid=0, busy=0, done=0, latched mask=0 and counter=0; rst SHALL win over start, ready and stop.
REQ-028 Reset asserted mid-scan SHALL abort the scan with no done pulse, and the next scan SHALL require a new start.

Configuration
REQ-029 Macro SCAN_CONTINUOUS_EN SHALL select continuous scanning.
REQ-030 When SCAN_CONTINUOUS_EN is defined, the case in REQ-022 SHALL pulse done, wrap sel to the lowest set latched bit, and return to SETTLE; the scan SHALL end in IDLE (with no done pulse) at the first HOLD handshake or SETTLE cycle where stop=1.
REQ-031 When SCAN_CONTINUOUS_EN is undefined, the block SHALL implement single-pass scanning only, and stop SHALL be ignored.

Verification
REQ-032 mask=0x8000_0011, ready tied 1, SETTLE_CYC=1, mux_out=8'hA0+sel -> three transfers (ch=0 data A0, ch=4 data A4, ch=31 data BF), then a done pulse, then busy=0.
REQ-033 mask=0x0000_0004, ready held 0 for 5 cycles after valid -> data/ch/sel remain stable for all 5 cycles, and one transfer occurs on the first ready=1.
REQ-034 start with mask=0 -> done pulses 1 cycle later, valid never asserts, and busy stays 0.
REQ-035 rst asserted in SETTLE of channel 4 (mask=0x11) -> next cycle all outputs are 0 with no done pulse, and a later start restarts at ch=0.
REQ-036 SETTLE_CYC=3, mask=0x1 -> valid rises exactly 4 cycles after sel=0 is driven, and a start during busy is ignored.
REQ-037 With SCAN_CONTINUOUS_EN and mask=0x3 -> channel sequence 0,1,0,1 with a done pulse at each wrap, ending in IDLE after stop=1.
